// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for memory_arbiter: FSM encoding, port-owner encoding, widths and the
// latched-request record.
package memory_arbiter_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned CntW  = 8;

  typedef enum logic [1:0] {
    ArbIdle   = 2'd0,
    ArbAccess = 2'd1,
    ArbAck    = 2'd2
  } arb_state_e;

  typedef enum logic {
    ArbOwnerIf = 1'b0,
    ArbOwnerD  = 1'b1
  } arb_owner_e;

  // Request captured in IDLE and held for the whole access window.
  typedef struct packed {
    arb_owner_e         owner;
    logic               write;
    logic [AddrW-1:0]   addr;
    logic [DataW-1:0]   wdata;
  } arb_req_t;

  function automatic arb_owner_e other_owner(arb_owner_e o);
    return (o == ArbOwnerD) ? ArbOwnerIf : ArbOwnerD;
  endfunction

endpackage

// File: rtl/memory_arbiter_priority.sv
// Combinational grant picker (arb_priority) for memory_arbiter.
// ARB_ROUND_ROBIN_EN selects alternating grants on contention; otherwise D beats IF.
module memory_arbiter_priority
  import memory_arbiter_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  arb_owner_e last_grant,
`endif
  output logic       grant_valid,
  output arb_owner_e grant_owner
);

  always_comb begin
    grant_valid = if_req | d_req;
    grant_owner = ArbOwnerIf;
    if (if_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_owner = other_owner(last_grant);
`else
      // The data access belongs to the older instruction.
      grant_owner = ArbOwnerD;
`endif
    end else if (d_req) begin
      grant_owner = ArbOwnerD;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store, one access at a
// time through an IDLE/ACCESS/ACK FSM. Optional ARB_ROUND_ROBIN_EN enables fair arbitration.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_req,
  input  logic [AddrW-1:0] if_addr,
  output logic [DataW-1:0] if_rdata,
  output logic             if_ack,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [AddrW-1:0] d_addr,
  input  logic [DataW-1:0] d_wdata,
  output logic [DataW-1:0] d_rdata,
  output logic             d_ack,
  output logic [AddrW-1:0] mem_Address,
  output logic             mem_ReadEnable,
  output logic             mem_WriteEnable,
  output logic [DataW-1:0] mem_WriteData,
  input  logic [DataW-1:0] mem_ReadData,
  output logic             busy
);

  localparam logic [CntW-1:0] CntInit = CntW'(WAIT_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  arb_req_t         req_q, req_d;
  logic             re_q, re_d;
  logic             we_q, we_d;
  logic             if_ack_q, if_ack_d;
  logic             d_ack_q, d_ack_d;
  logic             busy_q, busy_d;
  logic [DataW-1:0] if_rdata_q, if_rdata_d;
  logic [DataW-1:0] d_rdata_q, d_rdata_d;

  logic             grant_valid;
  arb_owner_e       grant_owner;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_e       last_grant_q;
`endif

  memory_arbiter_priority u_priority (
    .if_req      (if_req),
    .d_req       (d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant  (last_grant_q),
`endif
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Registered outputs are computed from the next state, so they line up with the FSM state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    re_d       = 1'b0;
    we_d       = 1'b0;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (state_q)
      ArbIdle: begin
        if (grant_valid) begin
          req_d.owner = grant_owner;
          req_d.write = (grant_owner == ArbOwnerD) && d_we;
          req_d.addr  = (grant_owner == ArbOwnerD) ? d_addr : if_addr;
          if (req_d.write) begin
            req_d.wdata = d_wdata;
          end
          cnt_d   = CntInit;
          re_d    = !req_d.write;
          we_d    = req_d.write;
          state_d = ArbAccess;
        end
      end
      ArbAccess: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
          re_d  = !req_q.write;
          we_d  = req_q.write;
        end else begin
          if (!req_q.write) begin
            if (req_q.owner == ArbOwnerD) begin
              d_rdata_d = mem_ReadData;
            end else begin
              if_rdata_d = mem_ReadData;
            end
          end
          if (req_q.owner == ArbOwnerD) begin
            d_ack_d = 1'b1;
          end else begin
            if_ack_d = 1'b1;
          end
          state_d = ArbAck;
        end
      end
      ArbAck: begin
        state_d = ArbIdle;
      end
      default: begin
        state_d = ArbIdle;
      end
    endcase

    busy_d = (state_d != ArbIdle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ArbIdle;
      cnt_q      <= '0;
      req_q      <= '0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      re_q       <= re_d;
      we_q       <= we_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      busy_q     <= busy_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Resets to D so the first contention goes to IF.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_q <= ArbOwnerD;
    end else if (state_q == ArbIdle && grant_valid) begin
      last_grant_q <= grant_owner;
    end
  end
`endif

  assign mem_Address     = req_q.addr;
  assign mem_WriteData   = req_q.wdata;
  assign mem_ReadEnable  = re_q;
  assign mem_WriteEnable = we_q;
  assign if_ack          = if_ack_q;
  assign d_ack           = d_ack_q;
  assign if_rdata        = if_rdata_q;
  assign d_rdata         = d_rdata_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter: three instances (WAIT_CYCLES 1, 2, 4) share
// one stimulus, each with its own behavioural memory.
module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;

  logic [31:0] if_rdata1, d_rdata1, addr1, wd1, rd1;
  logic        if_ack1, d_ack1, re1, we1, busy1;
  logic [31:0] if_rdata2, d_rdata2, addr2, wd2, rd2;
  logic        if_ack2, d_ack2, re2, we2, busy2;
  logic [31:0] if_rdata4, d_rdata4, addr4, wd4, rd4;
  logic        if_ack4, d_ack4, re4, we4, busy4;

  logic [31:0] mem1 [0:4095];
  logic [31:0] mem2 [0:4095];
  logic [31:0] mem4 [0:4095];

  int n_checks = 0;
  int n_errors = 0;
  int overlap  = 0;
  int ack2_cnt = 0;
  int ack4_cnt = 0;

  always #5 clock = ~clock;

  memory_arbiter #(.WAIT_CYCLES(1)) u_w1 (
    .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1),
    .if_ack(if_ack1), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata1), .d_ack(d_ack1), .mem_Address(addr1), .mem_ReadEnable(re1),
    .mem_WriteEnable(we1), .mem_WriteData(wd1), .mem_ReadData(rd1), .busy(busy1)
  );
  memory_arbiter #(.WAIT_CYCLES(2)) u_w2 (
    .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata2),
    .if_ack(if_ack2), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata2), .d_ack(d_ack2), .mem_Address(addr2), .mem_ReadEnable(re2),
    .mem_WriteEnable(we2), .mem_WriteData(wd2), .mem_ReadData(rd2), .busy(busy2)
  );
  memory_arbiter #(.WAIT_CYCLES(4)) u_w4 (
    .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata4),
    .if_ack(if_ack4), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata4), .d_ack(d_ack4), .mem_Address(addr4), .mem_ReadEnable(re4),
    .mem_WriteEnable(we4), .mem_WriteData(wd4), .mem_ReadData(rd4), .busy(busy4)
  );

  // Memories: combinational read, write on the clock edge, preload while reset is low.
  assign rd1 = re1 ? mem1[addr1[11:0]] : 32'h0;
  assign rd2 = re2 ? mem2[addr2[11:0]] : 32'h0;
  assign rd4 = re4 ? mem4[addr4[11:0]] : 32'h0;

  always @(posedge clock) begin
    if (!reset) begin
      mem1[16] <= 32'hDEADBEEF;  mem1[48] <= 32'hCAFEF00D;
      mem2[16] <= 32'hDEADBEEF;  mem2[48] <= 32'hCAFEF00D;
      mem4[16] <= 32'hDEADBEEF;  mem4[48] <= 32'hCAFEF00D;
    end else begin
      if (we1) mem1[addr1[11:0]] <= wd1;
      if (we2) mem2[addr2[11:0]] <= wd2;
      if (we4) mem4[addr4[11:0]] <= wd4;
    end
  end

  always @(negedge clock) begin
    if ((re1 && we1) || (re2 && we2) || (re4 && we4)) overlap++;
    if (if_ack2) ack2_cnt++;
    if (if_ack4) ack4_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    if_req = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  // Counts negedges until the selected ack of the W=1 instance shows, bounded at 20.
  task automatic wait_ack1(input bit on_d, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(on_d ? d_ack1 : if_ack1) && n < 20);
  endtask

  initial begin
    int n;
    int snap;
    logic [3:0] seq;

    // 1: reset held with random requests, then released idle.
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      if_req = 1'($urandom);
      d_req = 1'($urandom);
      d_we = 1'($urandom);
      if_addr = 32'($urandom);
      d_addr = 32'($urandom);
      d_wdata = 32'($urandom);
      step(1);
    end
    check("rst_ctrl", {27'd0, if_ack1, d_ack1, re1, we1, busy1}, 32'd0);
    check("rst_if_rdata", if_rdata1, 32'd0);
    check("rst_d_rdata", d_rdata1, 32'd0);
    check("rst_addr", addr1, 32'd0);
    check("rst_wdata", wd1, 32'd0);
    if_req = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
    reset = 1'b1;
    step(3);
    check("idle_after_release", {29'd0, busy1, re1, we1}, 32'd0);

    // 2: single fetch, WAIT_CYCLES=1.
    if_req = 1'b1;
    if_addr = 32'h10;
    step(1);
    check("fetch_re_on", {31'd0, re1}, 32'd1);
    check("fetch_addr", addr1, 32'h10);
    check("fetch_no_early_ack", {31'd0, if_ack1}, 32'd0);
    if_req = 1'b0;
    step(1);
    check("fetch_re_off", {31'd0, re1}, 32'd0);
    check("fetch_ack", {31'd0, if_ack1}, 32'd1);
    check("fetch_rdata", if_rdata1, 32'hDEADBEEF);
    step(1);
    check("fetch_ack_one_cycle", {30'd0, if_ack1, busy1}, 32'd0);

    // 3: data read, data write, fetch back the written word.
    do_reset();
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h30;
    wait_ack1(1'b1, n);
    check("dread_latency", n, 32'd2);
    check("dread_rdata", d_rdata1, 32'hCAFEF00D);
    d_req = 1'b0;
    step(1);
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h20;
    d_wdata = 32'h12345678;
    step(1);
    check("dwrite_en", {30'd0, re1, we1}, 32'd1);
    check("dwrite_data", wd1, 32'h12345678);
    check("dwrite_addr", addr1, 32'h20);
    wait_ack1(1'b1, n);
    check("dwrite_ack", n, 32'd1);
    check("dwrite_mem", mem1[32], 32'h12345678);
    check("dwrite_d_rdata_kept", d_rdata1, 32'hCAFEF00D);
    d_req = 1'b0;
    d_we = 1'b0;
    step(1);
    if_req = 1'b1;
    if_addr = 32'h20;
    wait_ack1(1'b0, n);
    check("refetch_latency", n, 32'd2);
    check("refetch_rdata", if_rdata1, 32'h12345678);
    check("refetch_d_rdata_kept", d_rdata1, 32'hCAFEF00D);
    if_req = 1'b0;

    // 4: contention with both requests held.
    do_reset();
    if_req = 1'b1;
    if_addr = 32'h10;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h30;
`ifdef ARB_ROUND_ROBIN_EN
    seq = 4'b0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!(if_ack1 || d_ack1) && n < 20);
      check("rr_interval", n, (g == 0) ? 32'd2 : 32'd3);
      seq = {seq[2:0], d_ack1};
    end
    check("rr_order", {28'd0, seq}, 32'b0101);
    if_req = 1'b0;
    d_req = 1'b0;
`else
    wait_ack1(1'b1, n);
    check("prio_d_first", n, 32'd2);
    check("prio_no_if_ack", {31'd0, if_ack1}, 32'd0);
    d_req = 1'b0;
    wait_ack1(1'b0, n);
    check("prio_if_gap", n, 32'd3);
    check("prio_if_rdata", if_rdata1, 32'hDEADBEEF);
    if_req = 1'b0;
`endif

    // 5: reset in the 2nd ACCESS cycle, WAIT_CYCLES=4.
    do_reset();
    if_req = 1'b1;
    if_addr = 32'h10;
    step(1);
    check("w4_access1_re", {31'd0, re4}, 32'd1);
    step(1);
    snap = ack4_cnt;
    reset = 1'b0;
    if_req = 1'b0;
    #1;
    check("w4_abort_en", {29'd0, re4, we4, busy4}, 32'd0);
    step(2);
    reset = 1'b1;
    step(8);
    check("w4_abort_no_ack", ack4_cnt - snap, 32'd0);
    check("w4_idle_after", {31'd0, busy4}, 32'd0);
    if_req = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!if_ack4 && n < 20);
    check("w4_fetch_latency", n, 32'd5);
    check("w4_fetch_rdata", if_rdata4, 32'hDEADBEEF);
    if_req = 1'b0;

    // 6: held fetch request, WAIT_CYCLES=2, ten accesses.
    do_reset();
    snap = ack2_cnt;
    if_req = 1'b1;
    if_addr = 32'h10;
    for (int a = 0; a < 10; a++) begin
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!if_ack2 && n < 20);
      check("w2_ack_spacing", n, (a == 0) ? 32'd3 : 32'd4);
    end
    if_req = 1'b0;
    step(8);
    check("w2_ack_count", ack2_cnt - snap, 32'd10);
    check("w2_rdata", if_rdata2, 32'hDEADBEEF);

    check("re_we_overlap", overlap, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
